// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues word reads to imem over
// req/ack, and queues {instruction, npc} pairs for the ID stage over valid/ready.
module if_prefetch_queue #(
  parameter int DEPTH    = 4,
  parameter int AW       = 10,
  parameter int RESET_PC = 0
) (
  input  logic                       clk1,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [AW-1:0]              imem_addr,
  input  logic                       imem_ack,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect,
  input  logic [AW-1:0]              redirect_pc,
  input  logic                       halt,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [31:0]                id_ir,
  output logic [31:0]                id_npc,
  output logic [$clog2(DEPTH+1)-1:0] q_count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [AW-1:0] RESET_PC_C = AW'(RESET_PC);

  // S_IDLE: no request | S_WAIT: request out, keep data | S_DRAIN: request out, drop data
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_req;
  logic            w_req_nxt;
  logic [AW-1:0]   r_addr;
  logic [AW-1:0]   w_addr_nxt;
  logic [AW-1:0]   r_fetch_pc;
  logic [AW-1:0]   w_pc_nxt;
  logic [AW-1:0]   w_addr_inc;
  logic            r_halted;
  logic            w_halted_nxt;

  logic [31:0]     r_ir_mem  [DEPTH];
  logic [AW-1:0]   r_npc_mem [DEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_count_nxt;
  logic            w_push;
  logic            w_pop;
  logic            w_issue_ok;

  assign w_addr_inc   = r_addr + AW'(1);
  assign w_halted_nxt = r_halted | halt;

  assign id_valid  = (r_count != '0);
  assign id_ir     = id_valid ? r_ir_mem[r_rd_ptr] : 32'd0;
  assign id_npc    = id_valid ? {{(32-AW){1'b0}}, r_npc_mem[r_rd_ptr]} : 32'd0;
  assign q_count   = r_count;
  assign imem_req  = r_req;
  assign imem_addr = r_addr;

  // Issue decision looks at next-cycle occupancy so a push never meets a full queue.
  always_comb begin
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_count_nxt = r_count;
    w_issue_ok  = 1'b0;
    w_push      = (r_state == S_WAIT) && imem_ack && !redirect;
    w_pop       = id_valid && id_ready && !redirect;
    if (redirect) begin
      w_count_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CW'(1);
    end
    w_issue_ok = !w_halted_nxt && (w_count_nxt < DEPTH_C);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_addr_nxt  = r_addr;
    w_pc_nxt    = r_fetch_pc;
    unique case (r_state)
      S_IDLE: begin
        if (redirect) begin
          w_pc_nxt = redirect_pc;
        end else if (w_issue_ok) begin
          w_state_nxt = S_WAIT;
          w_req_nxt   = 1'b1;
          w_addr_nxt  = r_fetch_pc;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          w_pc_nxt = redirect_pc;
          if (imem_ack) begin
            w_state_nxt = S_IDLE;
            w_req_nxt   = 1'b0;
          end else begin
            w_state_nxt = S_DRAIN;
          end
        end else if (imem_ack) begin
          w_pc_nxt = w_addr_inc;
          if (w_issue_ok) begin
            w_addr_nxt = w_addr_inc;
          end else begin
            w_state_nxt = S_IDLE;
            w_req_nxt   = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        if (redirect) begin
          w_pc_nxt = redirect_pc;
        end
        if (imem_ack) begin
          w_state_nxt = S_IDLE;
          w_req_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_req_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_addr     <= RESET_PC_C;
      r_fetch_pc <= RESET_PC_C;
      r_halted   <= 1'b0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_req      <= w_req_nxt;
      r_addr     <= w_addr_nxt;
      r_fetch_pc <= w_pc_nxt;
      r_halted   <= w_halted_nxt;
      r_count    <= w_count_nxt;
      if (redirect) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk1) begin
    if (!rst && w_push) begin
      r_ir_mem[r_wr_ptr]  <= imem_rdata;
      r_npc_mem[r_wr_ptr] <= w_addr_inc;
    end
  end

endmodule
